// File: rtl/clc_gx_pow.sv
// Raw power g^x by right-to-left square-and-multiply, one exponent bit per cycle.
// Result is truncated to RW bits; ovf flags that the true power did not fit.
module clc_gx_pow #(
  parameter int unsigned GW = 32,
  parameter int unsigned XW = 32,
  parameter int unsigned RW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [GW-1:0] g,
  input  logic [XW-1:0] x,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] exp,
  output logic          exp_vld,
  output logic          ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] base_q, base_d;
  logic          base_big_q, base_big_d;
  logic [XW-1:0] e_q, e_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic [RW-1:0] exp_q, exp_d;
  logic          exp_vld_q, exp_vld_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [2*RW-1:0] prod;
  logic [2*RW-1:0] sq;
  logic [XW-1:0]   e_shr;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    base_d     = base_q;
    base_big_d = base_big_q;
    e_d        = e_q;
    ovf_acc_d  = ovf_acc_q;
    exp_d      = exp_q;
    exp_vld_d  = exp_vld_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    prod  = (2*RW)'(acc_q) * (2*RW)'(base_q);
    sq    = (2*RW)'(base_q) * (2*RW)'(base_q);
    e_shr = e_q >> 1;

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d      = RW'(1);
          base_d     = RW'(g);
          base_big_d = 1'b0;
          e_d        = x;
          ovf_acc_d  = 1'b0;
          ovf_d      = 1'b0;
          exp_vld_d  = 1'b0;
          state_d    = (x == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (e_q[0]) begin
          acc_d     = prod[RW-1:0];
          ovf_acc_d = ovf_acc_q | base_big_q | (|prod[2*RW-1:RW]);
        end
        // Skip the final squaring: its value is never used and could spuriously flag overflow.
        if (e_shr != '0) begin
          base_d     = sq[RW-1:0];
          base_big_d = base_big_q | (|sq[2*RW-1:RW]);
        end
        e_d = e_shr;
        if (e_shr == '0) state_d = StDone;
      end
      StDone: begin
        exp_d     = acc_q;
        exp_vld_d = 1'b1;
        ovf_d     = ovf_acc_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // busy stays up through the done pulse.
    busy_d = (state_d != StIdle) | done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      base_q     <= '0;
      base_big_q <= 1'b0;
      e_q        <= '0;
      ovf_acc_q  <= 1'b0;
      exp_q      <= '0;
      exp_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      base_big_q <= base_big_d;
      e_q        <= e_d;
      ovf_acc_q  <= ovf_acc_d;
      exp_q      <= exp_d;
      exp_vld_q  <= exp_vld_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign exp     = exp_q;
  assign exp_vld = exp_vld_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_clc_gx_pow.sv
// Scoreboard bench for clc_gx_pow: directed vectors push expected results,
// a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_clc_gx_pow;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] g;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [63:0] exp;
  logic        exp_vld;
  logic        ovf;

  clc_gx_pow #(.GW(32), .XW(32), .RW(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .g       (g),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .exp     (exp),
    .exp_vld (exp_vld),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    logic        ovf;
    logic        chk_exp;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bitlen(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 64'(cyc - e.t0), 64'(e.lat));
        if (e.chk_exp) check("exp", exp, e.exp);
        check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
        check("exp_vld_at_done", {63'd0, exp_vld}, 64'd1);
      end
    end
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  // intr=1 pokes a second start mid-run, which must be ignored.
  task automatic run(input logic [31:0] gv, input logic [31:0] xv, input logic [63:0] ev,
                     input logic ov, input logic ce, input logic intr);
    exp_t e;
    @(negedge clk);
    e.exp = ev; e.ovf = ov; e.chk_exp = ce; e.lat = bitlen(xv) + 1; e.t0 = cyc + 1;
    sb.push_back(e);
    start = 1'b1; g = gv; x = xv;
    @(negedge clk);
    start = 1'b0; g = $urandom; x = $urandom;
    if (intr) begin
      check("busy_in_run", {63'd0, busy}, 64'd1);
      check("exp_vld_cleared", {63'd0, exp_vld}, 64'd0);
      repeat (3) @(negedge clk);
      start = 1'b1; g = 32'd5; x = 32'd1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    @(negedge clk);
    check("busy_after", {63'd0, busy}, 64'd0);
    check("done_pulse_len", {63'd0, done}, 64'd0);
    check("exp_vld_hold", {63'd0, exp_vld}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; g = 32'd9; x = 32'd9;
    repeat (2) @(negedge clk);
    check("rst_exp", exp, 64'd0);
    check("rst_flags", {59'd0, busy, done, exp_vld, ovf, 1'b0}, 64'd0);
    rst = 1'b0; start = 1'b0;

    // 125 mod 17 = 6 downstream.
    run(32'd5, 32'd3, 64'd125, 1'b0, 1'b1, 1'b0);
    run(32'd7, 32'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    run(32'd0, 32'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    run(32'd0, 32'd5, 64'd0, 1'b0, 1'b1, 1'b0);
    run(32'd2, 32'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run(32'd2, 32'd64, 64'd0, 1'b1, 1'b1, 1'b0);
    run(32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, 1'b0);
    // (2^32-1)^3 mod 2^64 = 3*2^32 - 1
    run(32'hFFFF_FFFF, 32'd3, 64'h0000_0002_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run(32'd1, 32'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
    run(32'd3, 32'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b1);

    // Reset two cycles into a run: nothing may surface.
    @(negedge clk);
    start = 1'b1; g = 32'd5; x = 32'd40;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_exp", exp, 64'd0);
    check("mid_rst_exp_vld", {63'd0, exp_vld}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    repeat (45) @(negedge clk);
    run(32'd5, 32'd3, 64'd125, 1'b0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clc_gx_pow.md
# clc_gx_pow

- Computes the raw power g^x with right-to-left binary (square-and-multiply) exponentiation, one exponent bit per cycle.
- Sits directly upstream of the R1 mod-p stage: its `exp` output and `exp_vld` level drive that stage's `exp` and `st` inputs, which then form R1 = g^x mod p.
- The result is truncated to RW bits; a sticky `ovf` flag reports when the true value did not fit.

## Interface
Parameters:
- GW, 32, width of base `g`
- XW, 32, width of exponent `x`
- RW, 64, width of result `exp`; must satisfy RW >= GW

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- g  in  GW  base; captured on the accepted start edge
- x  in  XW  exponent; captured on the accepted start edge
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when the result is written
- exp  out  RW  g^x truncated to RW bits, held stable
- exp_vld  out  1  level; high from done until the next accepted start; drives downstream `st`
- ovf  out  1  true g^x >= 2^RW; valid while exp_vld is high

## Operation
States: IDLE, RUN, DONE. All outputs are registered.

Internal registers:
- acc (RW): running result
- base (RW) and base_big: squared base and its overflow bit
- e (XW): remaining exponent

IDLE:
- When start=1, load acc=1, base=zero-extended g, base_big=0, e=x, ovf=0, and clear exp_vld.
- If x=0, go to DONE; otherwise go to RUN.
- start=0 leaves everything unchanged; exp and exp_vld hold.

RUN, one edge per exponent bit. With b=e[0]:
- If b=1: acc <= low RW bits of acc*base (full 2RW-bit product). Set ovf if base_big=1 or product bits [2RW-1:RW] are nonzero.
- If e>>1 != 0: base <= low RW bits of base*base. Set base_big if base_big=1 or the square's high half is nonzero.
- If e>>1 == 0: the squaring update is skipped.
- e <= e>>1.
- Go to DONE when e>>1 == 0.

DONE, single cycle:
- exp <= acc, exp_vld <= 1, done <= 1 for this cycle only.
- Go to IDLE.

Arithmetic rules:
- Products are unsigned.
- ovf is sticky within one computation and cleared on the next accepted start.
- g=0 and x>0 gives exp=0, ovf=0.
- g=1 gives exp=1 for any x, ovf=0.
- x=0 gives exp=1, including for g=0.

Boundary cases:
- start while busy (RUN or DONE) is ignored; the captured g and x are unaffected.
- start coinciding with rst: rst wins.
- Inputs g and x may change freely after the capture edge.

## Timing
Let N be the bit length of x (index of its MSB plus 1; N=0 for x=0).

- Accepted start at edge 0. RUN covers edges 1..N. done is high for exactly one cycle, from edge N+1 to edge N+2.
  - Latency from start to done: N+1 cycles. Maximum is XW+1 = 33.
- exp, exp_vld and ovf update at the same edge that raises done.
- busy rises the edge after the accepted start and falls with done.
- A new start is accepted in the first cycle after done falls.
- Throughput: one result every N+2 cycles.
- exp_vld falls the edge after the next accepted start; exp keeps its old value until the new done.

Reset, applied in any state including mid-RUN: at the next edge,
- the FSM returns to IDLE;
- exp=0, exp_vld=0, done=0, busy=0, ovf=0;
- all internal registers are cleared;
- no partial result becomes visible.

## Test plan
- g=5, x=3 (N=2): done 3 cycles after start; exp=125, ovf=0, exp_vld=1. Downstream with p=17 yields r1=6.
- g=7, x=0: done 1 cycle after start; exp=1. Also g=0, x=0 gives exp=1, and g=0, x=5 gives exp=0 with ovf=0.
- g=2, x=63 (N=6): done 7 cycles after start; exp=0x8000_0000_0000_0000, ovf=0.
- g=2, x=64: exp=0, ovf=1. g=0xFFFF_FFFF, x=2: exp=0xFFFF_FFFE_0000_0001, ovf=0. Same g with x=3 gives ovf=1.
- Start g=3, x=0xFFFF_FFFF, then pulse start with g=5, x=1 during RUN: the second start is ignored; done arrives 33 cycles after the first start with ovf=1.
- Assert rst two cycles into a run with x=40: all outputs read 0 the next cycle. A fresh start g=5, x=3 then produces exp=125 normally.
